// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic LEGv8 requests (R/D/CB formats) into 32-bit
// words, buffers them in a small circular FIFO and streams them, with
// sequential byte addresses, to an instruction-memory write port.
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op_sel,
    input  logic [4:0]        rd,
    input  logic [4:0]        rn,
    input  logic [4:0]        rm,
    input  logic [18:0]       imm,
    input  logic              restart,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_instr,
    output logic              err_illegal,
    output logic [15:0]       words_written
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_ORR  = 3'd3;
    localparam logic [2:0] OP_LDUR = 3'd4;
    localparam logic [2:0] OP_STUR = 3'd5;
    localparam logic [2:0] OP_CBZ  = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    // Pack one request into its machine word; the illegal opcode yields zero
    // but is never stored.
    function automatic logic [31:0] encodeInstr(
        input logic [2:0]  op,
        input logic [4:0]  fRd,
        input logic [4:0]  fRn,
        input logic [4:0]  fRm,
        input logic [18:0] fImm
    );
        logic [31:0] word;
        case (op)
            OP_ADD:  word = {11'b10001011000, fRm, 6'b000000, fRn, fRd};
            OP_SUB:  word = {11'b11001011000, fRm, 6'b000000, fRn, fRd};
            OP_AND:  word = {11'b10001010000, fRm, 6'b000000, fRn, fRd};
            OP_ORR:  word = {11'b10101010000, fRm, 6'b000000, fRn, fRd};
            OP_LDUR: word = {11'b11111000010, fImm[8:0], 2'b00, fRn, fRd};
            OP_STUR: word = {11'b11111000000, fImm[8:0], 2'b00, fRn, fRd};
            OP_CBZ:  word = {8'b10110100, fImm, fRd};
            default: word = 32'h0000_0000;
        endcase
        return word;
    endfunction

    logic [31:0]      fifoMem [DEPTH];
    logic [PTR_W:0]   wrPtr;
    logic [PTR_W:0]   rdPtr;
    logic [ADDR_W-1:0] headAddr;

    logic fifoFull;
    logic fifoEmpty;
    logic accept;
    logic isIllegal;
    logic doPush;
    logic doPop;
    logic [31:0] encWord;

    // Full when pointers differ only in the wrap bit; empty when identical.
    assign fifoFull  = (wrPtr[PTR_W] != rdPtr[PTR_W]) &&
                       (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
    assign fifoEmpty = (wrPtr == rdPtr);

    assign in_ready  = !fifoFull;
    assign out_valid = !fifoEmpty;
    assign out_instr = fifoMem[rdPtr[PTR_W-1:0]];
    assign out_addr  = headAddr;

    // Handshake qualification; restart discards any transfer in its cycle.
    always_comb begin
        accept    = 1'b0;
        isIllegal = 1'b0;
        doPush    = 1'b0;
        doPop     = 1'b0;
        encWord   = encodeInstr(op_sel, rd, rn, rm, imm);
        if (restart) begin
            accept    = 1'b0;
            isIllegal = 1'b0;
            doPush    = 1'b0;
            doPop     = 1'b0;
        end else begin
            accept    = in_valid && !fifoFull;
            isIllegal = accept && (op_sel == OP_ILL);
            doPush    = accept && (op_sel != OP_ILL);
            doPop     = !fifoEmpty && out_ready;
        end
    end

    // Storage array; contents need no reset because validity lives in the pointers.
    always_ff @(posedge clk) begin
        if (doPush) begin
            fifoMem[wrPtr[PTR_W-1:0]] <= encWord;
        end else begin
            fifoMem[wrPtr[PTR_W-1:0]] <= fifoMem[wrPtr[PTR_W-1:0]];
        end
    end

    // Pointers, head address, pop counter and the illegal-request pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr         <= '0;
            rdPtr         <= '0;
            headAddr      <= BASE;
            words_written <= 16'h0000;
            err_illegal   <= 1'b0;
        end else if (restart) begin
            wrPtr         <= '0;
            rdPtr         <= '0;
            headAddr      <= BASE;
            words_written <= 16'h0000;
            err_illegal   <= 1'b0;
        end else begin
            err_illegal <= isIllegal;
            if (doPush) begin
                wrPtr <= wrPtr + (PTR_W + 1)'(1);
            end else begin
                wrPtr <= wrPtr;
            end
            if (doPop) begin
                rdPtr    <= rdPtr + (PTR_W + 1)'(1);
                headAddr <= headAddr + ADDR_W'(4);
                if (words_written != 16'hFFFF) begin
                    words_written <= words_written + 16'h0001;
                end else begin
                    words_written <= words_written;
                end
            end else begin
                rdPtr         <= rdPtr;
                headAddr      <= headAddr;
                words_written <= words_written;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed, table-driven bench for instr_encoder. A second instance with a
// 4-bit address port shares all inputs to observe address wrap-around.
module tb_instr_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [2:0]  op_sel;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [18:0] imm;
    logic        restart;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_addr;
    logic [31:0] out_instr;
    logic        err_illegal;
    logic [15:0] words_written;

    logic        in_ready4;
    logic        out_valid4;
    logic [3:0]  out_addr4;
    logic [31:0] out_instr4;
    logic        err_illegal4;
    logic [15:0] words_written4;

    int nVec = 0;
    int nErr = 0;

    instr_encoder #(.DEPTH(4), .ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .rd(rd), .rn(rn), .rm(rm), .imm(imm),
        .restart(restart), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_instr(out_instr),
        .err_illegal(err_illegal), .words_written(words_written)
    );

    instr_encoder #(.DEPTH(4), .ADDR_W(4), .BASE_ADDR(0)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .op_sel(op_sel), .rd(rd), .rn(rn), .rm(rm), .imm(imm),
        .restart(restart), .out_valid(out_valid4), .out_ready(out_ready),
        .out_addr(out_addr4), .out_instr(out_instr4),
        .err_illegal(err_illegal4), .words_written(words_written4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  vRd;
        logic [4:0]  vRn;
        logic [4:0]  vRm;
        logic [18:0] vImm;
        logic [31:0] expWord;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [4:0] d,
                         input logic [4:0] n, input logic [4:0] m, input logic [18:0] i);
        in_valid = v;
        op_sel   = op;
        rd       = d;
        rn       = n;
        rm       = m;
        imm      = i;
    endtask

    // Pulse reset between clock edges (called at a falling edge).
    task automatic pulseReset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{3'd0, 5'd1,  5'd2,  5'd3,  19'd0,       32'h8B030041}; // ADD
        vecs[1] = '{3'd1, 5'd1,  5'd2,  5'd3,  19'd0,       32'hCB030041}; // SUB
        vecs[2] = '{3'd4, 5'd5,  5'd6,  5'd0,  19'd8,       32'hF84080C5}; // LDUR
        vecs[3] = '{3'd5, 5'd5,  5'd6,  5'd0,  19'd8,       32'hF80080C5}; // STUR
        vecs[4] = '{3'd6, 5'd9,  5'd0,  5'd0,  19'd3,       32'hB4000069}; // CBZ
        vecs[5] = '{3'd2, 5'd31, 5'd0,  5'd31, 19'd0,       32'h8A1F001F}; // AND
        vecs[6] = '{3'd3, 5'd0,  5'd31, 5'd0,  19'd0,       32'hAA0003E0}; // ORR
        vecs[7] = '{3'd4, 5'd0,  5'd0,  5'd0,  19'h7FFFF,   32'hF85FF000}; // LDUR imm trunc
        vecs[8] = '{3'd6, 5'd0,  5'd0,  5'd0,  19'h7FFFF,   32'hB4FFFFE0}; // CBZ max imm
        vecs[9] = '{3'd0, 5'd31, 5'd31, 5'd31, 19'h7FFFF,   32'h8B1F03FF}; // ADD imm ignored

        rst = 1'b1;
        restart = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_words", 32'(words_written), 32'd0);
        check("rst_err", 32'(err_illegal), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Streaming table: one push per cycle, each word popped the cycle after.
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].vRd, vecs[i].vRn, vecs[i].vRm, vecs[i].vImm);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_instr", i), out_instr, vecs[i].expWord);
            check($sformatf("vec%0d_addr", i), 32'(out_addr), 32'((4 * i) % 256));
            check($sformatf("vec%0d_addr4", i), 32'(out_addr4), 32'((4 * i) % 16));
            check($sformatf("vec%0d_words", i), 32'(words_written), 32'(i));
        end
        drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
        @(posedge clk);
        @(negedge clk);
        check("stream_drained", 32'(out_valid), 32'd0);
        check("stream_words", 32'(words_written), 32'(NV));

        // Illegal request between two ADDs.
        pulseReset();
        drive(1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 19'd0);
        @(posedge clk);
        @(negedge clk);
        check("ill_add0_addr", 32'(out_addr), 32'd0);
        check("ill_err_before", 32'(err_illegal), 32'd0);
        drive(1'b1, 3'd7, 5'd1, 5'd2, 5'd3, 19'd0);
        @(posedge clk);
        @(negedge clk);
        check("ill_err_pulse", 32'(err_illegal), 32'd1);
        check("ill_nothing_queued", 32'(out_valid), 32'd0);
        drive(1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 19'd0);
        @(posedge clk);
        @(negedge clk);
        check("ill_err_single", 32'(err_illegal), 32'd0);
        check("ill_add1_instr", out_instr, 32'h8B030041);
        check("ill_add1_addr", 32'(out_addr), 32'd4);
        drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
        @(posedge clk);
        @(negedge clk);
        check("ill_words", 32'(words_written), 32'd2);
        check("ill_err_after", 32'(err_illegal), 32'd0);

        // Backpressure: 5 offered at DEPTH 4 with the memory stalled.
        pulseReset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 3'd0, 5'(k), 5'd2, 5'd3, 19'd0);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp_ready%0d", k), 32'(in_ready), (k == 3) ? 32'd0 : 32'd1);
        end
        drive(1'b1, 3'd0, 5'd4, 5'd2, 5'd3, 19'd0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("bp_held_ready", 32'(in_ready), 32'd0);
        check("bp_held_instr", out_instr, 32'h8B030040);
        check("bp_held_addr", 32'(out_addr), 32'd0);
        check("bp_held_words", 32'(words_written), 32'd0);
        out_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (j == 1) begin
                check("bp_ready_after_pop", 32'(in_ready), 32'd1);
            end
            if (j == 2) begin
                drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
            end
            check($sformatf("bp_drain%0d_instr", j), out_instr, 32'h8B030040 | 32'(j));
            check($sformatf("bp_drain%0d_addr", j), 32'(out_addr), 32'(4 * j));
        end
        @(posedge clk);
        @(negedge clk);
        check("bp_empty", 32'(out_valid), 32'd0);
        check("bp_words", 32'(words_written), 32'd5);

        // Restart while holding two words, with a push/pop/illegal in that cycle.
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 5'd7, 5'd7, 5'd7, 19'd0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("rs_pre_valid", 32'(out_valid), 32'd1);
        check("rs_pre_addr", 32'(out_addr), 32'd20);
        out_ready = 1'b1;
        restart = 1'b1;
        drive(1'b1, 3'd7, 5'd0, 5'd0, 5'd0, 19'd0);
        @(posedge clk);
        @(negedge clk);
        restart = 1'b0;
        drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
        check("rs_valid", 32'(out_valid), 32'd0);
        check("rs_addr", 32'(out_addr), 32'd0);
        check("rs_words", 32'(words_written), 32'd0);
        check("rs_err_suppressed", 32'(err_illegal), 32'd0);
        check("rs_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset mid-drain.
        drive(1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 19'd0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("ar_pre_addr", 32'(out_addr), 32'd4);
        drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_ready", 32'(in_ready), 32'd1);
        check("ar_addr", 32'(out_addr), 32'd0);
        check("ar_words", 32'(words_written), 32'd0);
        #1;
        rst = 1'b0;
        drive(1'b1, 3'd4, 5'd5, 5'd6, 5'd0, 19'd8);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
        check("ar_fresh_instr", out_instr, 32'hF84080C5);
        check("ar_fresh_addr", 32'(out_addr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming LEGv8 instruction encoder and instruction-memory writer: the encode-side counterpart of the datapath's opcode decoder. It accepts symbolic instruction requests (operation select plus register and immediate fields) over a valid/ready handshake. It packs each request into a 32-bit R-, D- or CB-format word and buffers it in a small FIFO. It streams the words with sequential byte addresses to the instruction-memory write port, so test programs can be loaded before the CPU runs.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2
- ADDR_W, 8: byte-address width of the instruction-memory port
- BASE_ADDR, 0: address of the first word written after reset or restart; multiple of 4
- clk  in  1  single clock; everything samples on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  encoder can accept (= FIFO not full)
- op_sel  in  3  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 LDUR, 5 STUR, 6 CBZ, 7 illegal
- rd  in  5  Rd (R-type) / Rt (D, CB)
- rn  in  5  Rn (R, D)
- rm  in  5  Rm (R only)
- imm  in  19  D: DT_address = imm[8:0]; CB: cond_br_address = imm[18:0]; ignored for R
- restart  in  1  synchronous flush and address reload
- out_valid  out  1  head word available
- out_ready  in  1  memory accepts write this cycle
- out_addr  out  ADDR_W  byte address for out_instr
- out_instr  out  32  encoded word
- err_illegal  out  1  one-cycle pulse: illegal request dropped
- words_written  out  16  count of words popped since reset/restart, saturating at 0xFFFF

## Operation
- Accept when in_valid && in_ready. Encode combinationally at acceptance and store the 32-bit word in the FIFO.
- R-type (op 0–3):
  - word = {opc[10:0], rm, 6'b0, rn, rd}
  - opc: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000
- D-type (op 4,5):
  - word = {opc, imm[8:0], 2'b00, rn, rd}
  - opc: LDUR 11111000010, STUR 11111000000
- CB-type (op 6): word = {8'b10110100, imm[18:0], rd}.
- op 7:
  - Handshake completes (in_ready unaffected); nothing is enqueued.
  - err_illegal pulses high in the following cycle.
  - Address and counter are unchanged.
- Pop when out_valid && out_ready.
  - out_addr advances by 4, wrapping modulo 2^ADDR_W.
  - words_written increments, saturating.
- out_addr is a registered address counter giving the address of the current head word.
- FIFO:
  - Circular, with log2(DEPTH)+1-bit pointers; full/empty are decoded from the pointer MSB.
  - in_ready = !full. While full, no push is accepted even if a pop occurs in the same cycle.
  - Simultaneous push and pop when neither full nor empty: both happen and the occupancy is unchanged.
- restart:
  - Empties the FIFO, loads out_addr = BASE_ADDR and clears words_written.
  - A push or pop in the same cycle is discarded. in_ready/out_valid are still driven normally; the transfer is simply lost.
  - err_illegal is suppressed that cycle.
- rst: FIFO empty, out_addr = BASE_ADDR, words_written = 0, err_illegal = 0, out_valid = 0, in_ready = 1. out_instr is undefined while out_valid = 0.

## Timing
- Push-to-visible latency: 1 cycle. A word accepted at edge N gives out_valid = 1 after edge N; there is no combinational in→out bypass.
- out_valid, out_instr and out_addr hold stable while out_valid && !out_ready.
- Back-to-back throughput: 1 word/cycle when out_ready is held high and input is continuous.
- A full FIFO deasserts in_ready in the cycle after the DEPTH-th push. It reasserts the cycle after a pop.
- Address wrap: from 2^ADDR_W−4 the next pop yields 0.
- Reset mid-stream: all state clears asynchronously; outputs take their reset values immediately, without waiting for a clock edge.

## Test plan
- ADD X1,X2,X3 (op 0, rd 1, rn 2, rm 3), out_ready 1 → next cycle out_instr 0x8B030041, out_addr 0x00; then SUB with the same fields → 0xCB030041, addr 0x04.
- LDUR X5,[X6,#8] (op 4, rd 5, rn 6, imm 8) → 0xF84080C5; STUR with the same fields → 0xF80080C5; CBZ X9,#3 (op 6, rd 9, imm 3) → 0xB4000069.
- out_ready 0 with 5 pushes offered at DEPTH 4 → 4 accepted, in_ready low on the 5th and it is held. Raise out_ready → 4 words drain in order at addrs 0,4,8,C and the 5th is then accepted.
- Illegal op 7 between two ADDs → err_illegal pulses once, the two ADD words are at consecutive addrs 0x00/0x04, and words_written = 2.
- ADDR_W 4, 5 pops → addrs 0,4,8,C,0 (wrap); restart with the FIFO holding 2 words → out_valid 0 next cycle, out_addr 0, words_written 0.
- Assert rst mid-drain → out_valid 0, in_ready 1 and out_addr BASE_ADDR before the next clock edge; after release, a fresh push is written at BASE_ADDR.
